alu4: RTL and testbench

- Registered 4-bit arithmetic/logic unit: add, subtract, AND, OR on two unsigned/two's-complement operands, selected by a 2-bit opcode.
- Sits in the datapath as a single-cycle execute stage.
- Operands and opcode are sampled every rising clock edge; result and flags are registered, giving one cycle of latency.

---
 rtl/alu4.sv | 83 ++++++++
 tb/tb_alu4.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu4.sv
// Registered arithmetic/logic execute stage: ADD, SUB, AND, OR on two operands.
// Result and flags are computed combinationally and captured together on each rising edge.
module alu4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] b_opnd;
  logic             carry_in;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] out_d,      out_q;
  logic             carry_d,    carry_q;
  logic             zero_d,     zero_q;
  logic             overflow_d, overflow_q;

  // ADD and SUB share one adder; SUB feeds ~B with a carry-in of 1.
  always_comb begin
    op       = op_e'(S);
    b_opnd   = (op == OP_SUB) ? ~B : B;
    carry_in = (op == OP_SUB);
    sum      = {1'b0, A} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, carry_in};
  end

  always_comb begin
    out_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (op)
      OP_ADD: begin
        out_d      = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        out_d      = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: out_d = A & B;
      OP_OR:  out_d = A | B;
      default: out_d = '0;
    endcase
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Out      = out_q;
  assign CarryOut = carry_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu4.sv
// Directed bench for alu4: reset, ADD/SUB/logic vectors, latency, mid-cycle stability, async reset.
module tb_alu4;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] S;
  logic [3:0] Out;
  logic       CarryOut;
  logic       Zero;
  logic       Overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu4 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .S        (S),
    .Out      (Out),
    .CarryOut (CarryOut),
    .Zero     (Zero),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] eo, input logic ec,
                       input logic ez, input logic ev);
    checks++;
    assert (Out === eo) else begin
      errors++;
      $error("FAIL %s Out: got %b expected %b", tag, Out, eo);
    end
    checks++;
    assert (CarryOut === ec) else begin
      errors++;
      $error("FAIL %s CarryOut: got %b expected %b", tag, CarryOut, ec);
    end
    checks++;
    assert (Zero === ez) else begin
      errors++;
      $error("FAIL %s Zero: got %b expected %b", tag, Zero, ez);
    end
    checks++;
    assert (Overflow === ev) else begin
      errors++;
      $error("FAIL %s Overflow: got %b expected %b", tag, Overflow, ev);
    end
  endtask

  // Drive inputs just after an edge, capture on the next edge, sample 1 time unit later.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input logic [3:0] eo, input logic ec,
                      input logic ez, input logic ev);
    A = a;
    B = b;
    S = s;
    @(posedge clk);
    #1;
    check(tag, eo, ec, ez, ev);
  endtask

  initial begin
    rst = 1'b1;
    A   = 4'b1111;
    B   = 4'b0001;
    S   = 2'b00;
    #1;
    check("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_edge", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    step("add_c_c",   4'b1100, 4'b1100, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0);
    step("add_4_9",   4'b0100, 4'b1001, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0);
    step("add_5_1",   4'b0101, 4'b0001, 2'b00, 4'b0110, 1'b0, 1'b0, 1'b0);
    step("add_6_8",   4'b0110, 4'b1000, 2'b00, 4'b1110, 1'b0, 1'b0, 1'b0);
    step("add_0_f",   4'b0000, 4'b1111, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("add_3_5",   4'b0011, 4'b0101, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b1);
    step("add_f_1",   4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("add_8_8",   4'b1000, 4'b1000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1);

    step("sub_9_5",   4'b1001, 4'b0101, 2'b01, 4'b0100, 1'b1, 1'b0, 1'b1);
    step("sub_3_3",   4'b0011, 4'b0011, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("sub_9_3",   4'b1001, 4'b0011, 2'b01, 4'b0110, 1'b1, 1'b0, 1'b1);
    step("sub_f_0",   4'b1111, 4'b0000, 2'b01, 4'b1111, 1'b1, 1'b0, 1'b0);
    step("sub_2_7",   4'b0010, 4'b0111, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b0);
    step("sub_7_8",   4'b0111, 4'b1000, 2'b01, 4'b1111, 1'b0, 1'b0, 1'b1);

    step("and_c_c",   4'b1100, 4'b1100, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b0);
    step("and_5_1",   4'b0101, 4'b0001, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0);
    step("and_0_f",   4'b0000, 4'b1111, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("and_f_f",   4'b1111, 4'b1111, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("or_4_9",    4'b0100, 4'b1001, 2'b11, 4'b1101, 1'b0, 1'b0, 1'b0);
    step("or_6_8",    4'b0110, 4'b1000, 2'b11, 4'b1110, 1'b0, 1'b0, 1'b0);
    step("or_f_0",    4'b1111, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("or_0_0",    4'b0000, 4'b0000, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Hold inputs: outputs stay put across further edges.
    @(posedge clk);
    #1;
    check("hold_stable", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Mid-cycle toggling must not reach the outputs before the next edge.
    step("pre_toggle", 4'b1001, 4'b0101, 2'b01, 4'b0100, 1'b1, 1'b0, 1'b1);
    A = 4'b0011;
    B = 4'b0101;
    S = 2'b00;
    #2;
    check("toggle_mid1", 4'b0100, 1'b1, 1'b0, 1'b1);
    A = 4'b0000;
    B = 4'b1111;
    S = 2'b10;
    #2;
    check("toggle_mid2", 4'b0100, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("toggle_edge", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Async reset while SUB 1001-0101 is pending.
    step("pre_rst", 4'b1100, 4'b1100, 2'b00, 4'b1000, 1'b1, 1'b0, 1'b0);
    A = 4'b1001;
    B = 4'b0101;
    S = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_through_edge", 4'b0000, 1'b0, 1'b0, 1'b0);
    A = 4'b0101;
    B = 4'b0001;
    S = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    check("rst_released", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("after_rst", 4'b0110, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
